wb_port_arbiter: RTL and testbench

Arbiter for the single register-file write port. It shares the port between the pipeline writeback stage (the MEM/WB output after the MemtoReg mux) and result returns from long-latency units such as mult/div. Pipeline writes always win. Long-latency results wait in a 2-entry in-order buffer and drain into idle writeback slots. A starvation FSM requests a pipeline bubble when a buffered result waits too long.

---
 rtl/wb_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between the WB stage
// and long-latency results held in a 2-entry in-order buffer.
package wb_port_arbiter_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    STARVED = 1'b1
  } starve_st_t;
endpackage

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        ext_valid,
  input  logic [4:0]  ext_rd,
  input  logic [31:0] ext_data,
  output logic        ext_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] rd_busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_ent_t    ent_q [2];
  wb_ent_t    ent_n [2];
  wb_ent_t    push_ent;
  logic [1:0] count_q;
  logic [1:0] count_n;
  logic [3:0] age_q;
  logic [3:0] age_n;
  starve_st_t st_q;
  starve_st_t st_n;
  logic       stall_n;

  logic        pipe_eff;
  logic        push;
  logic        pop;
  logic        keep0;
  logic        keep1;
  logic        rf_we_n;
  logic [4:0]  rf_waddr_n;
  logic [31:0] rf_wdata_n;

  assign ext_ready = (count_q != 2'd2);
  assign pipe_eff  = pipe_we && (pipe_rd != 5'd0);
  assign push      = ext_valid && ext_ready && (ext_rd != 5'd0);
  assign pop       = !pipe_eff && (count_q != 2'd0);
  assign push_ent  = {ext_rd, ext_data};

  // A pipe write is always younger than buffered entries: kill older WAW
  assign keep0 = (count_q != 2'd0) && !pop &&
                 !(pipe_eff && (ent_q[0].rd == pipe_rd));
  assign keep1 = (count_q == 2'd2) &&
                 !(pipe_eff && (ent_q[1].rd == pipe_rd));

  always_comb begin
    ent_n   = ent_q;
    count_n = 2'(keep0) + 2'(keep1) + 2'(push);
    if (keep0) begin
      ent_n[1] = keep1 ? ent_q[1] : push_ent;
    end else if (keep1) begin
      ent_n[0] = ent_q[1];
      ent_n[1] = push_ent;
    end else begin
      ent_n[0] = push_ent;
    end
  end

  always_comb begin
    age_n = 4'd0;
    if (keep0) begin
      age_n = (age_q >= LIMIT) ? LIMIT : age_q + 4'd1;
    end
  end

  always_comb begin
    rf_we_n    = 1'b0;
    rf_waddr_n = rf_waddr;
    rf_wdata_n = rf_wdata;
    unique case (1'b1)
      pipe_eff: begin
        rf_we_n    = 1'b1;
        rf_waddr_n = pipe_rd;
        rf_wdata_n = pipe_data;
      end
      pop: begin
        rf_we_n    = 1'b1;
        rf_waddr_n = ent_q[0].rd;
        rf_wdata_n = ent_q[0].data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= 2'd0;
      age_q    <= 4'd0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      ent_q    <= ent_n;
      count_q  <= count_n;
      age_q    <= age_n;
      rf_we    <= rf_we_n;
      rf_waddr <= rf_waddr_n;
      rf_wdata <= rf_wdata_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= NORMAL;
      stall_req <= 1'b0;
    end else begin
      st_q      <= st_n;
      stall_req <= stall_n;
    end
  end

  // Only a head that is still waiting may enter or stay in STARVED
  always_comb begin
    st_n = st_q;
    unique case (st_q)
      NORMAL:  if (keep0 && (age_q >= LIMIT)) st_n = STARVED;
      STARVED: if (!keep0) st_n = NORMAL;
      default: st_n = NORMAL;
    endcase
  end

  always_comb begin
    stall_n = (st_n == STARVED);
  end

  always_comb begin
    rd_busy = 32'd0;
    if (count_q != 2'd0) rd_busy[ent_q[0].rd] = 1'b1;
    if (count_q == 2'd2) rd_busy[ent_q[1].rd] = 1'b1;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected RF writes are queued
// by the stimulus and consumed by a negedge monitor.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        ext_valid = 1'b0;
  logic [4:0]  ext_rd = '0;
  logic [31:0] ext_data = '0;
  logic        ext_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] rd_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .pipe_we(pipe_we),
    .pipe_rd(pipe_rd),
    .pipe_data(pipe_data),
    .ext_valid(ext_valid),
    .ext_rd(ext_rd),
    .ext_data(ext_data),
    .ext_ready(ext_ready),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .stall_req(stall_req),
    .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: unexpected rd=%0d data=%h",
                 rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.rd || rf_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL rf_write: got rd=%0d data=%h expected rd=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd,
                       input logic [31:0] pd, input logic ev,
                       input logic [4:0] erd, input logic [31:0] ed);
    pipe_we   = pwe;
    pipe_rd   = prd;
    pipe_data = pd;
    ext_valid = ev;
    ext_rd    = erd;
    ext_data  = ed;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_stall"}, 32'(stall_req), 32'd0);
    chk({tag, "_ext_ready"}, 32'(ext_ready), 32'd1);
    chk({tag, "_rd_busy"}, rd_busy, 32'd0);
  endtask

  initial begin
    idle();
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b1;
    tick();

    // single buffered result, idle pipe
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("push5_busy", rd_busy, 32'h0000_0020);
    chk("push5_nobypass", 32'(rf_we), 32'd0);
    expw(5'd5, 32'hDEADBEEF);
    tick();
    chk("drain5_busy", rd_busy, 32'd0);
    chk("drain5_data", rf_wdata, 32'hDEADBEEF);
    tick();
    chk("drain5_idle", 32'(rf_we), 32'd0);

    // pipe busy, fill buffer, starve, then drain
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    expw(5'd10, 32'hA0);
    tick();
    drive(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44);
    expw(5'd11, 32'hA1);
    tick();
    chk("full_ready", 32'(ext_ready), 32'd0);
    chk("full_busy", rd_busy, 32'h0000_0018);
    for (int i = 2; i <= 5; i++) begin
      drive(1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b0, 5'd0, 32'd0);
      expw(5'(10 + i), 32'(32'hA0 + i));
      tick();
      if (i == 4) chk("stall_pre", 32'(stall_req), 32'd0);
      if (i == 5) chk("stall_up", 32'(stall_req), 32'd1);
    end
    idle();
    expw(5'd3, 32'h33);
    tick();
    chk("stall_down", 32'(stall_req), 32'd0);
    chk("after_pop3_busy", rd_busy, 32'h0000_0010);
    chk("after_pop3_ready", 32'(ext_ready), 32'd1);
    expw(5'd4, 32'h44);
    tick();
    chk("after_pop4_busy", rd_busy, 32'd0);

    // WAW cancel of an older buffered entry
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd7, 32'h11);
    expw(5'd20, 32'h200);
    tick();
    chk("waw_busy", rd_busy, 32'h0000_0080);
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    expw(5'd7, 32'h22);
    tick();
    chk("waw_cleared", rd_busy, 32'd0);
    chk("waw_ready", 32'(ext_ready), 32'd1);
    idle();
    tick();
    chk("waw_no_old", 32'(rf_we), 32'd0);

    // same-edge accept with matching rd is younger and survives
    drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd8, 32'h81);
    expw(5'd8, 32'h80);
    tick();
    chk("young_busy", rd_busy, 32'h0000_0100);
    idle();
    expw(5'd8, 32'h81);
    tick();
    chk("young_drained", rd_busy, 32'd0);

    // rd=0 handling
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    tick();
    chk("rd0_ext_busy", rd_busy, 32'd0);
    chk("rd0_ext_ready", 32'(ext_ready), 32'd1);
    idle();
    tick();
    chk("rd0_ext_nowrite", 32'(rf_we), 32'd0);
    drive(1'b1, 5'd21, 32'h210, 1'b1, 5'd12, 32'h120);
    expw(5'd21, 32'h210);
    tick();
    drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    expw(5'd12, 32'h120);
    tick();
    chk("rd0_pipe_pop_busy", rd_busy, 32'd0);
    tick();
    chk("rd0_pipe_we", 32'(rf_we), 32'd0);
    chk("rd0_hold_addr", 32'(rf_waddr), 32'd12);
    chk("rd0_hold_data", rf_wdata, 32'h120);

    // simultaneous push and pop at count=1
    drive(1'b1, 5'd22, 32'h220, 1'b1, 5'd6, 32'h60);
    expw(5'd22, 32'h220);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90);
    expw(5'd6, 32'h60);
    tick();
    chk("pushpop_busy", rd_busy, 32'h0000_0200);
    chk("pushpop_ready", 32'(ext_ready), 32'd1);
    idle();
    expw(5'd9, 32'h90);
    tick();
    chk("pushpop_drained", rd_busy, 32'd0);

    // reset with a full buffer
    drive(1'b1, 5'd23, 32'h230, 1'b1, 5'd13, 32'hD);
    expw(5'd23, 32'h230);
    tick();
    drive(1'b1, 5'd24, 32'h240, 1'b1, 5'd14, 32'hE);
    expw(5'd24, 32'h240);
    tick();
    chk("prerst_ready", 32'(ext_ready), 32'd0);
    chk("prerst_busy", rd_busy, 32'h0000_6000);
    idle();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_state("midrst");
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF0);
    tick();
    chk("postrst_busy", rd_busy, 32'h0000_8000);
    idle();
    expw(5'd15, 32'hF0);
    tick();
    chk("postrst_drained", rd_busy, 32'd0);
    tick();
    tick();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
